mod_counter: RTL and testbench

- Free-running modulo-(M+1) up-counter with count-enable and terminal-count carry output.
- Used as a frame/bit counter in serial DAC transmit logic. With M=15 it marks every 16th clock so a 16-bit shift register can reload and the chip-select can toggle once per word.
- Carry output is intended for cascading and for framing strobes.

---
 rtl/mod_counter.sv | 49 ++++
 tb/tb_mod_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// mod_counter: free-running modulo-(M+1) up-counter with enable and carry.
// Wraps by compare so non-power-of-two moduli never show values above M.
module mod_counter #(
  parameter int unsigned M = 15,
  localparam int unsigned CW =
    ($clog2(M + 1) < 1) ? 1 : $clog2(M + 1)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          en,
  output logic          co,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] TERM = CW'(M);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_term;

  assign at_term = (cnt_q == TERM);

  // Next count: hold, increment, or wrap to zero at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (at_term) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Count register, cleared asynchronously by areset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  // Carry follows en combinationally; masked so it is low during reset.
  assign co  = en & at_term & ~areset;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: vector table plus scoreboard for mod_counter.
// Covers M=15, M=9 and a cascaded pair of M=3 counters.
module tb_mod_counter;

  logic       aclk = 1'b0;
  logic       areset = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;

  logic       co_a;
  logic [3:0] cnt_a;
  logic       co_9;
  logic [3:0] cnt_9;
  logic       co_c1;
  logic [1:0] cnt_c1;
  logic       co_c2;
  logic [1:0] cnt_c2;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       co;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] cnt;
    logic       co;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  mod_counter #(.M(15)) u_a (
    .aclk(aclk), .areset(areset), .en(en_a),
    .co(co_a), .cnt(cnt_a)
  );

  mod_counter #(.M(9)) u_9 (
    .aclk(aclk), .areset(areset), .en(en_b),
    .co(co_9), .cnt(cnt_9)
  );

  mod_counter #(.M(3)) u_c1 (
    .aclk(aclk), .areset(areset), .en(en_b),
    .co(co_c1), .cnt(cnt_c1)
  );

  mod_counter #(.M(3)) u_c2 (
    .aclk(aclk), .areset(areset), .en(co_c1),
    .co(co_c2), .cnt(cnt_c2)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Drive en_a at posedge+1, push expectation, compare at negedge.
  task automatic step(input logic e, input int ec, input logic eco);
    exp_t x;
    en_a = e;
    sb.push_back({4'(ec), eco});
    @(negedge aclk);
    x = sb.pop_front();
    chk("cnt_a", int'(cnt_a), int'(x.cnt));
    chk("co_a", int'(co_a), int'(x.co));
    @(posedge aclk);
    #1;
  endtask

  // Pulse reset and release it just after an edge.
  task automatic do_reset();
    en_a = 1'b0;
    en_b = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b1;
    #2;
    chk("rst_cnt", int'(cnt_a), 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    int p_a;
    int p_9;
    int p_c2;
    int ex;
    logic e;
    exp_t x;

    // Vector table: enable gating then enable drop at terminal.
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 4'(i), 1'b0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 4'd5, 1'b0});
    for (int i = 5; i < 15; i++)
      tbl.push_back('{1'b1, 4'(i), 1'b0});
    tbl.push_back('{1'b0, 4'd15, 1'b0});
    tbl.push_back('{1'b0, 4'd15, 1'b0});
    tbl.push_back('{1'b1, 4'd15, 1'b1});
    tbl.push_back('{1'b1, 4'd0, 1'b0});

    #1;
    areset = 1'b1;
    #2;
    chk("init_cnt_a", int'(cnt_a), 0);
    chk("init_co_a", int'(co_a), 0);
    chk("init_cnt_9", int'(cnt_9), 0);
    chk("init_cnt_c2", int'(cnt_c2), 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Continuous count on every instance.
    p_a = 0;
    p_9 = 0;
    p_c2 = 0;
    en_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      en_a = 1'b1;
      sb.push_back({4'(k % 16), (k % 16) == 15});
      @(negedge aclk);
      x = sb.pop_front();
      chk("run_cnt_a", int'(cnt_a), int'(x.cnt));
      chk("run_co_a", int'(co_a), int'(x.co));
      chk("run_cnt_9", int'(cnt_9), k % 10);
      chk("run_co_9", int'(co_9), int'((k % 10) == 9));
      chk("run_le9", int'(cnt_9 <= 4'd9), 1);
      chk("run_cnt_c1", int'(cnt_c1), k % 4);
      chk("run_cnt_c2", int'(cnt_c2), (k / 4) % 4);
      chk("run_co_c2", int'(co_c2), int'((k % 16) == 15));
      if (co_a) p_a++;
      if (co_9) p_9++;
      if (co_c2) p_c2++;
      @(posedge aclk);
      #1;
    end
    chk("pulses_a", p_a, 2);
    chk("pulses_9", p_9, 4);
    chk("pulses_c2", p_c2, 2);

    // Table-driven gating and terminal-drop vectors.
    do_reset();
    foreach (tbl[i]) step(tbl[i].en, int'(tbl[i].cnt), tbl[i].co);

    // Async reset mid-cycle with cnt=7.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, i, 1'b0);
    en_a = 1'b1;
    #1;
    chk("pre_rst7", int'(cnt_a), 7);
    areset = 1'b1;
    #1;
    chk("arst7_cnt", int'(cnt_a), 0);
    chk("arst7_co", int'(co_a), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk);
      #1;
      chk("hold_rst_cnt", int'(cnt_a), 0);
      chk("hold_rst_co", int'(co_a), 0);
    end
    areset = 1'b0;
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);

    // Async reset while at the terminal count with en high.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, i, 1'b0);
    en_a = 1'b1;
    #1;
    chk("pre_rst15_co", int'(co_a), 1);
    areset = 1'b1;
    #1;
    chk("arst15_cnt", int'(cnt_a), 0);
    chk("arst15_co", int'(co_a), 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // en toggling every cycle.
    ex = 0;
    for (int i = 0; i < 12; i++) begin
      e = (i % 2) == 0;
      step(e, ex, 1'b0);
      if (e) ex++;
    end
    step(1'b0, 6, 1'b0);

    en_a = 1'b0;
    en_b = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
